// File: rtl/blvds_frame_tx_if.sv
// ---------------------------------------------------------------------------
// blvds_frame_tx_if
//   Bundles the control and BLVDS bus signals of blvds_frame_tx.
//   master : the frame transmitter (drives the bus and the status outputs)
//   slave  : the controller / consumer side (drives start, cont, injections)
//   Signals:
//     iSTART       start request
//     iCONT        continuous-mode request
//     oDATA_BLVDS  [15:0] data, [16] word valid, [17] header marker
//     oBUSY        high outside IDLE
//     oFRAME_DONE  one-cycle pulse per completed frame
//     oFRAME_CNT   completed-frame count (wraps)
//   With BLVDS_TX_ERR_INJ_EN defined, the error-injection requests
//   iINJ_HEAD, iINJ_EPILOG and iINJ_LEN are added.
// ---------------------------------------------------------------------------
interface blvds_frame_tx_if;
  logic        iSTART;
  logic        iCONT;
  logic [17:0] oDATA_BLVDS;
  logic        oBUSY;
  logic        oFRAME_DONE;
  logic [15:0] oFRAME_CNT;
`ifdef BLVDS_TX_ERR_INJ_EN
  logic        iINJ_HEAD;
  logic        iINJ_EPILOG;
  logic        iINJ_LEN;

  modport master (
    input  iSTART, iCONT, iINJ_HEAD, iINJ_EPILOG, iINJ_LEN,
    output oDATA_BLVDS, oBUSY, oFRAME_DONE, oFRAME_CNT
  );
  modport slave (
    output iSTART, iCONT, iINJ_HEAD, iINJ_EPILOG, iINJ_LEN,
    input  oDATA_BLVDS, oBUSY, oFRAME_DONE, oFRAME_CNT
  );
`else
  modport master (
    input  iSTART, iCONT,
    output oDATA_BLVDS, oBUSY, oFRAME_DONE, oFRAME_CNT
  );
  modport slave (
    output iSTART, iCONT,
    input  oDATA_BLVDS, oBUSY, oFRAME_DONE, oFRAME_CNT
  );
`endif
endinterface

// File: rtl/blvds_frame_tx.sv
// ---------------------------------------------------------------------------
// blvds_frame_tx
//   Frame generator for the 18-bit BLVDS bus. A frame is a header word,
//   FRAME_LEN payload words (word k = k + frame count held at HEAD), an
//   epilog word and GAP_CYCLES idle cycles. Continuous mode chains frames
//   back to back without an extra idle cycle.
//   Ports:
//     iCLK    bus clock (56 MHz domain)
//     iRST_N  asynchronous active-low reset
//     bus     blvds_frame_tx_if.master (start/cont in, bus and status out)
//   Optional feature (macro BLVDS_TX_ERR_INJ_EN): sticky error-injection
//   requests corrupting header/epilog data or lengthening the payload by
//   one word on the next frame.
//   All outputs are registered; they reflect the state of the previous cycle.
// ---------------------------------------------------------------------------
module blvds_frame_tx #(
  parameter logic [15:0] FRAME_LEN   = 16'd256,
  parameter logic [7:0]  GAP_CYCLES  = 8'd100,
  parameter logic [15:0] HEAD_WORD   = 16'hA5A5,
  parameter logic [15:0] EPILOG_WORD = 16'h5A5A
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  blvds_frame_tx_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    HEAD,
    PAYLOAD,
    EPILOG,
    GAP
  } state_t;

  state_t      state;
  state_t      nextState;
  logic [15:0] payIdx;
  logic [7:0]  gapCnt;
  logic [15:0] lastIdx;
  logic [15:0] headData;
  logic [15:0] epiData;
  logic        payLast;
  logic        gapFirst;
  logic        gapLast;

  logic [17:0] dataQ;
  logic [17:0] dataNext;
  logic        busyQ;
  logic        doneQ;
  logic [15:0] frameCnt;

`ifdef BLVDS_TX_ERR_INJ_EN
  logic pendHead, pendEpi, pendLen;
  logic actHead, actEpi, actLen;
  logic reqHead, reqEpi, reqLen;
  logic sampleInj;
  logic frameStart;

  // Requests are only accepted while no frame is on the bus; the value that
  // is pending when the next HEAD is entered (including a request seen on
  // that very edge) is frozen for the whole frame.
  assign sampleInj  = (state == IDLE) || (state == GAP);
  assign frameStart = sampleInj && (nextState == HEAD);
  assign reqHead    = pendHead | (sampleInj & bus.iINJ_HEAD);
  assign reqEpi     = pendEpi  | (sampleInj & bus.iINJ_EPILOG);
  assign reqLen     = pendLen  | (sampleInj & bus.iINJ_LEN);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      pendHead <= 1'b0;
      pendEpi  <= 1'b0;
      pendLen  <= 1'b0;
      actHead  <= 1'b0;
      actEpi   <= 1'b0;
      actLen   <= 1'b0;
    end else if (frameStart) begin
      actHead  <= reqHead;
      actEpi   <= reqEpi;
      actLen   <= reqLen;
      pendHead <= 1'b0;
      pendEpi  <= 1'b0;
      pendLen  <= 1'b0;
    end else begin
      pendHead <= reqHead;
      pendEpi  <= reqEpi;
      pendLen  <= reqLen;
    end
  end

  // Lengthened payload: index runs to FRAME_LEN, still fits in 16 bits.
  assign lastIdx  = actLen  ? FRAME_LEN : FRAME_LEN - 16'd1;
  assign headData = actHead ? ~HEAD_WORD   : HEAD_WORD;
  assign epiData  = actEpi  ? ~EPILOG_WORD : EPILOG_WORD;
`else
  assign lastIdx  = FRAME_LEN - 16'd1;
  assign headData = HEAD_WORD;
  assign epiData  = EPILOG_WORD;
`endif

  assign payLast  = (payIdx == lastIdx);
  assign gapFirst = (gapCnt == 8'd0);
  assign gapLast  = (gapCnt == GAP_CYCLES - 8'd1);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (bus.iSTART) nextState = HEAD;
      HEAD:    nextState = PAYLOAD;
      PAYLOAD: if (payLast) nextState = EPILOG;
      EPILOG:  nextState = GAP;
      GAP:     if (gapLast) nextState = bus.iCONT ? HEAD : IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      payIdx <= '0;
      gapCnt <= '0;
    end else begin
      if (state == PAYLOAD && !payLast) begin
        payIdx <= payIdx + 16'd1;
      end else begin
        payIdx <= '0;
      end
      if (state == GAP && !gapLast) begin
        gapCnt <= gapCnt + 8'd1;
      end else begin
        gapCnt <= '0;
      end
    end
  end

  always_comb begin
    dataNext = '0;
    unique case (state)
      HEAD:    dataNext = {2'b11, headData};
      PAYLOAD: dataNext = {2'b01, payIdx + frameCnt};
      EPILOG:  dataNext = {2'b01, epiData};
      default: dataNext = '0;
    endcase
  end

  // Output registers: the frame count only moves on the first GAP cycle, so
  // it is stable from HEAD through EPILOG and serves as the payload base.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      dataQ    <= '0;
      busyQ    <= 1'b0;
      doneQ    <= 1'b0;
      frameCnt <= '0;
    end else begin
      dataQ <= dataNext;
      busyQ <= (state != IDLE);
      doneQ <= (state == GAP) && gapFirst;
      if (state == GAP && gapFirst) begin
        frameCnt <= frameCnt + 16'd1;
      end
    end
  end

  assign bus.oDATA_BLVDS = dataQ;
  assign bus.oBUSY       = busyQ;
  assign bus.oFRAME_DONE = doneQ;
  assign bus.oFRAME_CNT  = frameCnt;

endmodule

// File: tb/tb_blvds_frame_tx.sv
// ---------------------------------------------------------------------------
// tb_blvds_frame_tx
//   Two transmitters (FRAME_LEN=4/GAP=3 and FRAME_LEN=1/GAP=1) share one
//   stimulus stream. Each has a frame-level reference model: a start pushes
//   the whole expected word sequence of a frame into a queue, one entry is
//   consumed per clock and compared with the bus and status outputs.
//   Define BLVDS_TX_ERR_INJ_EN to also exercise error injection.
// ---------------------------------------------------------------------------
module tb_blvds_frame_tx;

  logic iCLK = 1'b0;
  logic iRST_N;
  logic start, cont, injHead, injEpi, injLen;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  always #5 iCLK = ~iCLK;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [17:0] data;
    logic        busy;
    logic        done;
    logic        gapAny;
    logic        gapLast;
  } word_t;

  for (genvar g = 0; g < 2; g++) begin : gInst
    localparam logic [15:0] FL = (g == 0) ? 16'd4 : 16'd1;
    localparam logic [7:0]  GC = (g == 0) ? 8'd3  : 8'd1;

    blvds_frame_tx_if bus ();
    assign bus.iSTART = start;
    assign bus.iCONT  = cont;
`ifdef BLVDS_TX_ERR_INJ_EN
    assign bus.iINJ_HEAD   = injHead;
    assign bus.iINJ_EPILOG = injEpi;
    assign bus.iINJ_LEN    = injLen;
`endif

    blvds_frame_tx #(
      .FRAME_LEN  (FL),
      .GAP_CYCLES (GC),
      .HEAD_WORD  (16'hA5A5),
      .EPILOG_WORD(16'h5A5A)
    ) uDut (
      .iCLK  (iCLK),
      .iRST_N(iRST_N),
      .bus   (bus)
    );

    word_t       q[$];
    logic [15:0] mCnt = '0;
    bit          pH = 0, pE = 0, pL = 0;

    function automatic void pushFrame(input bit h, input bit e, input bit l);
      word_t w;
      int    n;
      w = '0;
      w.busy = 1'b1;
      w.data = {2'b11, (h ? 16'h5A5A : 16'hA5A5)};
      q.push_back(w);
      n = int'(FL) + (l ? 1 : 0);
      for (int k = 0; k < n; k++) begin
        w.data = {2'b01, 16'(mCnt + k[15:0])};
        q.push_back(w);
      end
      w.data = {2'b01, (e ? 16'hA5A5 : 16'h5A5A)};
      q.push_back(w);
      for (int j = 0; j < int'(GC); j++) begin
        w.data    = '0;
        w.done    = (j == 0);
        w.gapAny  = 1'b1;
        w.gapLast = (j == int'(GC) - 1);
        q.push_back(w);
      end
    endfunction

    always begin : model
      word_t cur;
      @(posedge iCLK);
      #1;
      if (!iRST_N) begin
        q.delete();
        mCnt = '0;
        pH = 0; pE = 0; pL = 0;
        cur = '0;
      end else begin
        if (q.size() > 0) cur = q.pop_front();
        else cur = '0;
        if (cur.done) mCnt = mCnt + 16'd1;
        if (!cur.busy || cur.gapAny) begin
          pH = pH | injHead;
          pE = pE | injEpi;
          pL = pL | injLen;
        end
        if (q.size() == 0 && ((!cur.busy && start) || (cur.gapLast && cont))) begin
          pushFrame(pH, pE, pL);
          pH = 0; pE = 0; pL = 0;
        end
      end
      checkVal($sformatf("i%0d.data", g), 32'(bus.oDATA_BLVDS), 32'(cur.data));
      checkVal($sformatf("i%0d.busy", g), 32'(bus.oBUSY),       32'(cur.busy));
      checkVal($sformatf("i%0d.done", g), 32'(bus.oFRAME_DONE), 32'(cur.done));
      checkVal($sformatf("i%0d.cnt",  g), 32'(bus.oFRAME_CNT),  32'(mCnt));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge iCLK);
  endtask

  task automatic pulseStart();
    @(negedge iCLK);
    start = 1'b1;
    @(negedge iCLK);
    start = 1'b0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkVal({tag, ".d0"}, 32'(gInst[0].bus.oDATA_BLVDS), 32'h0);
    checkVal({tag, ".b0"}, 32'(gInst[0].bus.oBUSY),       32'h0);
    checkVal({tag, ".c0"}, 32'(gInst[0].bus.oFRAME_CNT),  32'h0);
    checkVal({tag, ".d1"}, 32'(gInst[1].bus.oDATA_BLVDS), 32'h0);
    checkVal({tag, ".f1"}, 32'(gInst[1].bus.oFRAME_DONE), 32'h0);
  endtask

  initial begin
    start = 0; cont = 0; injHead = 0; injEpi = 0; injLen = 0;
    iRST_N = 1'b1;
    #1 iRST_N = 1'b0;
    cyc(3);
    checkResetOutputs("rst");
    iRST_N = 1'b1;

    // single frame
    pulseStart();
    cyc(15);

    // continuous mode, then drop back to single
    @(negedge iCLK);
    cont = 1'b1;
    pulseStart();
    cyc(30);
    cont = 1'b0;
    cyc(15);

    // start hammered while busy
    pulseStart();
    for (int i = 0; i < 14; i++) begin
      @(negedge iCLK);
      start = ~start;
    end
    start = 1'b0;
    cyc(15);

    // reset in the middle of the payload (after payload word 2 is on the bus)
    @(negedge iCLK);
    start = 1'b1;
    @(posedge iCLK);
    #1 start = 1'b0;
    repeat (4) @(posedge iCLK);
    #3 iRST_N = 1'b0;
    #1 checkResetOutputs("midrst");
    cyc(2);
    iRST_N = 1'b1;
    pulseStart();
    cyc(15);

    // frame count wrap: preset the counter while idle
    @(negedge iCLK);
    force gInst[0].uDut.frameCnt = 16'hFFFF;
    force gInst[1].uDut.frameCnt = 16'hFFFF;
    gInst[0].mCnt = 16'hFFFF;
    gInst[1].mCnt = 16'hFFFF;
    @(negedge iCLK);
    release gInst[0].uDut.frameCnt;
    release gInst[1].uDut.frameCnt;
    cyc(2);
    cont = 1'b1;
    pulseStart();
    cyc(16);
    cont = 1'b0;
    cyc(15);

`ifdef BLVDS_TX_ERR_INJ_EN
    @(negedge iCLK);
    injHead = 1'b1;
    @(negedge iCLK);
    injHead = 1'b0;
    pulseStart();
    cyc(12);
    pulseStart();
    cyc(12);
    @(negedge iCLK);
    injLen = 1'b1;
    injEpi = 1'b1;
    @(negedge iCLK);
    injLen = 1'b0;
    injEpi = 1'b0;
    pulseStart();
    cyc(14);
    pulseStart();
    cyc(14);
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge iCLK);
      start = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 29) == 0) cont = ~cont;
`ifdef BLVDS_TX_ERR_INJ_EN
      injHead = ($urandom_range(0, 39) == 0);
      injEpi  = ($urandom_range(0, 39) == 0);
      injLen  = ($urandom_range(0, 39) == 0);
`endif
      if ($urandom_range(0, 599) == 0) begin
        iRST_N = 1'b0;
        #1 checkResetOutputs("rndrst");
        @(negedge iCLK);
        iRST_N = 1'b1;
      end
    end
    start = 0; cont = 0; injHead = 0; injEpi = 0; injLen = 0;
    cyc(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
